// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the legality check used by
// the issue queue and the ALU itself.
package alu_pkg;

  localparam int ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 3'b100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 3'b101;

  // Encodings above ALU_SRL (110, 111) are undefined.
  function automatic logic is_legal_op(input logic [ALU_CTRL_W-1:0] op);
    return (op <= ALU_SRL);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers and a separate 0..DEPTH
// occupancy count. flush clears pointers and count, taking priority over
// push/pop. Overflowing pushes and underflowing pops are ignored.
module sync_fifo #(
  parameter int DW    = 35,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              wdata,
  output logic [DW-1:0]              rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok, wr_en;

  // Next-state for pointers and occupancy; flush wins over push/pop.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    push_ok  = push && (count_q != CW'(DEPTH));
    pop_ok   = pop && (count_q != '0);
    wr_en    = push_ok && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy masks stale entries.
    if (wr_en && !rst) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_issue_queue.sv
// Issue buffer in front of the ALU: queues {ctrl, a, b} from decode, drops
// and counts undefined opcodes, and presents the head entry (zeroed when
// empty) to the ALU operand inputs.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int ILL_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ALU_CTRL_W-1:0]   in_ctrl,
  input  logic [WIDTH-1:0]        in_a,
  input  logic [WIDTH-1:0]        in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ALU_CTRL_W-1:0]   out_ctrl,
  output logic [WIDTH-1:0]        out_a,
  output logic [WIDTH-1:0]        out_b,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    illegal_pulse,
  output logic [ILL_CNT_W-1:0]    illegal_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ALU_CTRL_W + 2 * WIDTH;

  logic [EW-1:0]         head;
  logic [ALU_CTRL_W-1:0] head_ctrl;
  logic [WIDTH-1:0]      head_a, head_b;
  logic [CW-1:0]         fifo_count;
  logic                  accept, fifo_push, fifo_pop, ill_hit;
  logic                  illegal_pulse_q, illegal_pulse_d;
  logic [ILL_CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;

  sync_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({in_ctrl, in_a, in_b}),
    .rdata (head),
    .count (fifo_count)
  );

  // Handshake, opcode filter and head gating; in_ready never looks at out_ready.
  always_comb begin
    in_ready  = !rst && (fifo_count != CW'(DEPTH));
    out_valid = (fifo_count != '0);
    accept    = in_valid && in_ready;
    fifo_push = accept && is_legal_op(in_ctrl);
    ill_hit   = accept && !is_legal_op(in_ctrl);
    fifo_pop  = out_valid && out_ready;
    {head_ctrl, head_a, head_b} = head;
    out_ctrl  = out_valid ? head_ctrl : '0;
    out_a     = out_valid ? head_a    : '0;
    out_b     = out_valid ? head_b    : '0;
  end

  // Illegal-op pulse and saturating counter next-state; flush does not clear them.
  always_comb begin
    illegal_pulse_d = ill_hit;
    illegal_cnt_d   = illegal_cnt_q;
    if (ill_hit && (illegal_cnt_q != '1)) illegal_cnt_d = illegal_cnt_q + ILL_CNT_W'(1);
  end

  // Illegal-op state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_pulse_q <= 1'b0;
      illegal_cnt_q   <= '0;
    end else begin
      illegal_pulse_q <= illegal_pulse_d;
      illegal_cnt_q   <= illegal_cnt_d;
    end
  end

  assign count         = fifo_count;
  assign illegal_pulse = illegal_pulse_q;
  assign illegal_cnt   = illegal_cnt_q;

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Issue buffer that sits directly upstream of the 32-bit ALU (ops ADD/SUB/AND/OR/SLL/SRL, flags Z/N/C/O).
- Accepts operations {alu_ctrl, a, b} from the decode stage over a valid/ready handshake and queues them in a small FIFO.
- Presents the head entry to the ALU operand inputs and pops it when downstream accepts.
- Filters undefined opcodes before they reach the ALU and counts them.

Parameters:
- WIDTH, 32, operand width; must match the ALU.
- DEPTH, 4, queue entries; power of two, at least 2.
- ILL_CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous queue clear.
- in_valid  input  1  upstream offers an op.
- in_ready  output  1  queue can accept an op this cycle.
- in_ctrl  input  3  ALU opcode.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b; the shift amount for SLL/SRL.
- out_valid  output  1  head entry valid.
- out_ready  input  1  ALU stage consumes the head entry.
- out_ctrl  output  3  head opcode, to ALU alu_ctrl.
- out_a  output  WIDTH  head operand a.
- out_b  output  WIDTH  head operand b.
- count  output  $clog2(DEPTH)+1  current occupancy.
- illegal_pulse  output  1  one-cycle pulse when an illegal op is dropped.
- illegal_cnt  output  ILL_CNT_W  saturating count of dropped illegal ops.

Behaviour:
- Reset (rst high at a rising edge):
  - count, read pointer and write pointer go to 0.
  - illegal_cnt and illegal_pulse go to 0.
  - out_valid goes to 0; out_ctrl, out_a and out_b go to 0.
  - in_ready is forced to 0 combinationally while rst is high.
  - A reset asserted mid-stream discards every entry with no pop.
- Handshake:
  - A push happens when in_valid && in_ready.
  - A pop happens when out_valid && out_ready.
  - in_ready = !rst && (count != DEPTH). It depends only on registered state, never on out_ready, so there is no pass-through when full.
  - out_valid = (count != 0).
  - out_ctrl, out_a and out_b come from the head entry when out_valid is 1, and are 0 when the queue is empty.
  - Head data must stay stable while out_valid && !out_ready.
- Legal opcodes are 000 through 101.
  - An opcode of 110 or 111 is still accepted (in_ready is honoured) but is not enqueued.
  - That cycle, illegal_pulse is 1 on the next cycle and illegal_cnt increments, saturating at all-ones.
  - count is unchanged by an illegal push.
- Latency: an entry pushed at edge N is visible on out_* after edge N (one cycle). There is no combinational bypass from in_* to out_*, including when the queue is empty.
- Simultaneous legal push and pop:
  - When 0 < count < DEPTH, count is unchanged and both pointers advance.
  - When empty, only the push takes effect, because out_valid is 0.
  - When full, only the pop takes effect, because in_ready is 0.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is separate and ranges 0..DEPTH.
- flush:
  - Clears count and both pointers at the edge.
  - Priority is rst > flush > push/pop; a push in the same cycle is dropped.
  - illegal_cnt is not cleared.
  - illegal_pulse still fires if the flushed-cycle push was illegal.
- The queue carries operand bit patterns unchanged; it does no arithmetic, sign handling or clamping of b.

Decomposition:
- Shared package alu_pkg, also used by the ALU:
  - Opcode localparams: ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLL=100, ALU_SRL=101.
  - ALU_CTRL_W=3.
  - An is_legal_op function.
- Natural sub-module: sync_fifo, parameterised by data width and DEPTH, providing storage, pointers and count.
- alu_issue_queue wraps sync_fifo and adds the opcode filter, the illegal counter and output gating.

Test Plan:
- Reset, then push ADD a=10 b=20 with out_ready=0 → after 1 cycle: out_valid=1, out_ctrl=000, out_a=10, out_b=20, count=1, in_ready=1.
- Push 4 legal ops (SUB 50/20, AND F0F0/0FF0, OR F0F0/0FF0, SLL 1/4) with out_ready=0 → count=4, in_ready=0. A 5th in_valid is ignored. Then out_ready=1 → the ops are popped in order, one per cycle, and count returns to 0.
- With count=2, hold in_valid=1 and out_ready=1 for 6 cycles → count stays 2 and the FIFO order is preserved across pointer wrap.
- Push ctrl=110 a=5 b=5 → count unchanged, illegal_pulse=1 for exactly one cycle, illegal_cnt=1. Then 256 more illegal pushes → illegal_cnt saturates at 255.
- Fill with 3 entries, then assert flush together with a legal push → count=0, out_valid=0, out_a=0 next cycle, and illegal_cnt is retained.
- Assert rst while count=3 and out_ready=0 → next cycle count=0, out_valid=0, and in_ready=0 while rst is high. Release rst → in_ready=1, and the first push after reset is the first one popped.
